pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage CPU. It produces hold and flush controls for the PC and for every pipeline register: IF_ID, ID_EX, EX_ME and ME_WB. The controls resolve four cases: load-use hazards, taken branches, multi-cycle multiply/divide occupancy of EX, and memory-stage wait states with timeout. The block sits beside the datapath and drives only control; it does not touch register data.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/hazard_detect.sv | 25 ++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and the
// destination index used for bubbles (x0, never a real write target).
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_MDU = 2'd1,
      ST_MEM = 2'd2
   } state_t;

   localparam logic [4:0] RD_BUBBLE = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID source that needs a load result still in EX.
// Purely combinational, no state; x0 never matches.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic       id_rs1_re_i,
   input  logic       id_rs2_re_i,
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   input  logic       ex_rd_we_i,
   input  logic [4:0] ex_rd_addr_i,
   input  logic       ex_is_load_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit = id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i);

   assign load_use_o = ex_is_load_i && ex_rd_we_i && (ex_rd_addr_i != RD_BUBBLE)
                       && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: hold/flush controls for memory wait, MDU
// occupancy, taken branches and load-use. Outputs combinational from state and inputs.
module pipe_ctrl
   import cpu_pkg::*;
#(
   parameter int MDU_LAT     = 4,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_rs1_re,
   input  logic       id_rs2_re,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       ex_rd_we,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_is_load,
   input  logic       ex_branch_taken,
   input  logic       ex_mdu_start,
   input  logic       me_req,
   input  logic       me_ack,
   output logic       pc_hold,
   output logic       if_id_hold,
   output logic       id_ex_hold,
   output logic       ex_me_hold,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_me_flush,
   output logic       me_wb_flush,
   output logic       mem_err,
   output logic       mdu_busy
);

   localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 2);
   localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   state_t     eff_st;
   logic [3:0] mdu_cnt_q, mdu_cnt_d;
   logic [7:0] mem_cnt_q, mem_cnt_d;
   logic       load_use;
   logic       stall_raw;
   logic       timeout;
   logic       freeze;
   logic       mdu_entry;
   logic       occupied;

   hazard_detect u_hazard (
      .id_rs1_re_i   (id_rs1_re),
      .id_rs2_re_i   (id_rs2_re),
      .id_rs1_addr_i (id_rs1_addr),
      .id_rs2_addr_i (id_rs2_addr),
      .ex_rd_we_i    (ex_rd_we),
      .ex_rd_addr_i  (ex_rd_addr),
      .ex_is_load_i  (ex_is_load),
      .load_use_o    (load_use)
   );

   // The cycle that leaves MEM (ack or timeout) behaves as the state it interrupted,
   // so an interrupted MDU operation keeps its exact occupancy count.
   assign eff_st    = (state_q == ST_MEM) ? ret_q : state_q;
   assign stall_raw = me_req && !me_ack;
   assign timeout   = stall_raw && (mem_cnt_q == MEM_LAST);
   assign freeze    = stall_raw && !timeout;
   assign mdu_entry = (eff_st == ST_RUN) && ex_mdu_start;
   assign occupied  = mdu_entry || ((eff_st == ST_MDU) && (mdu_cnt_q != 4'd0));

   always_comb begin
      state_d     = eff_st;
      ret_d       = ret_q;
      mdu_cnt_d   = mdu_cnt_q;
      mem_cnt_d   = 8'd0;
      pc_hold     = 1'b0;
      if_id_hold  = 1'b0;
      id_ex_hold  = 1'b0;
      ex_me_hold  = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_me_flush = 1'b0;
      me_wb_flush = 1'b0;
      mem_err     = 1'b0;
      mdu_busy    = 1'b0;
      if (freeze) begin
         state_d     = ST_MEM;
         if (state_q != ST_MEM) ret_d = state_q;
         mem_cnt_d   = mem_cnt_q + 8'd1;
         pc_hold     = 1'b1;
         if_id_hold  = 1'b1;
         id_ex_hold  = 1'b1;
         ex_me_hold  = 1'b1;
         me_wb_flush = 1'b1;
      end else begin
         me_wb_flush = timeout;
         mem_err     = timeout;
         if (occupied) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_me_flush = 1'b1;
            mdu_busy    = 1'b1;
            if (mdu_entry) begin
               state_d   = ST_MDU;
               mdu_cnt_d = MDU_LOAD;
            end else begin
               mdu_cnt_d = mdu_cnt_q - 4'd1;
            end
         end else begin
            if (eff_st == ST_MDU) state_d = ST_RUN;
            if (ex_branch_taken) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               pc_hold     = 1'b1;
               if_id_hold  = 1'b1;
               id_ex_flush = 1'b1;
            end
         end
      end
      if (rst) begin
         pc_hold     = 1'b0;
         if_id_hold  = 1'b0;
         id_ex_hold  = 1'b0;
         ex_me_hold  = 1'b0;
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
         ex_me_flush = 1'b0;
         me_wb_flush = 1'b0;
         mem_err     = 1'b0;
         mdu_busy    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         ret_q     <= ST_RUN;
         mdu_cnt_q <= 4'd0;
         mem_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         mdu_cnt_q <= mdu_cnt_d;
         mem_cnt_q <= mem_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MDU_LAT=4, MEM_TIMEOUT=8); expectations queued
// at drive time and compared against the outputs half a cycle later.
module tb_pipe_ctrl;

   typedef struct packed {
      logic       rst;
      logic       rs1_re;
      logic       rs2_re;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rd_we;
      logic [4:0] rd;
      logic       is_load;
      logic       br;
      logic       mdu;
      logic       req;
      logic       ack;
   } stim_t;

   typedef struct {
      logic [9:0] exp;
      logic [9:0] msk;
      string      tag;
   } exp_t;

   // {pc_hold, if_id_hold, id_ex_hold, ex_me_hold, if_id_flush, id_ex_flush,
   //  ex_me_flush, me_wb_flush, mem_err, mdu_busy}
   localparam logic [9:0] O_NONE = 10'b0000000000;
   localparam logic [9:0] O_LU   = 10'b1100010000;
   localparam logic [9:0] O_BR   = 10'b0000110000;
   localparam logic [9:0] O_MDU  = 10'b1110001001;
   localparam logic [9:0] O_FRZ  = 10'b1111000100;
   localparam logic [9:0] O_TO   = 10'b0000000110;
   localparam logic [9:0] M_ALL  = 10'b1111111111;
   localparam logic [9:0] M_FRZ  = 10'b1111111110;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_rs1_re, id_rs2_re;
   logic [4:0] id_rs1_addr, id_rs2_addr;
   logic       ex_rd_we;
   logic [4:0] ex_rd_addr;
   logic       ex_is_load, ex_branch_taken, ex_mdu_start, me_req, me_ack;
   logic       pc_hold, if_id_hold, id_ex_hold, ex_me_hold;
   logic       if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush;
   logic       mem_err, mdu_busy;

   int    checks   = 0;
   int    failures = 0;
   stim_t s;
   exp_t  sb_q[$];

   always #5 clk = ~clk;

   pipe_ctrl #(.MDU_LAT(4), .MEM_TIMEOUT(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1_re       (id_rs1_re),
      .id_rs2_re       (id_rs2_re),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .ex_rd_we        (ex_rd_we),
      .ex_rd_addr      (ex_rd_addr),
      .ex_is_load      (ex_is_load),
      .ex_branch_taken (ex_branch_taken),
      .ex_mdu_start    (ex_mdu_start),
      .me_req          (me_req),
      .me_ack          (me_ack),
      .pc_hold         (pc_hold),
      .if_id_hold      (if_id_hold),
      .id_ex_hold      (id_ex_hold),
      .ex_me_hold      (ex_me_hold),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_me_flush     (ex_me_flush),
      .me_wb_flush     (me_wb_flush),
      .mem_err         (mem_err),
      .mdu_busy        (mdu_busy)
   );

   task automatic apply(input stim_t v);
      rst             = v.rst;
      id_rs1_re       = v.rs1_re;
      id_rs2_re       = v.rs2_re;
      id_rs1_addr     = v.rs1;
      id_rs2_addr     = v.rs2;
      ex_rd_we        = v.rd_we;
      ex_rd_addr      = v.rd;
      ex_is_load      = v.is_load;
      ex_branch_taken = v.br;
      ex_mdu_start    = v.mdu;
      me_req          = v.req;
      me_ack          = v.ack;
   endtask

   // One cycle: drive s just after the edge, queue the expectation, check mid-cycle.
   task automatic step(input logic [9:0] exp, input logic [9:0] msk, input string tag);
      exp_t       e;
      logic [9:0] obs;
      @(posedge clk);
      #1;
      apply(s);
      e.exp = exp;
      e.msk = msk;
      e.tag = tag;
      sb_q.push_back(e);
      @(negedge clk);
      obs = {pc_hold, if_id_hold, id_ex_hold, ex_me_hold, if_id_flush, id_ex_flush,
             ex_me_flush, me_wb_flush, mem_err, mdu_busy};
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $error("FAIL %s scoreboard empty obs=%b", tag, obs);
      end else begin
         e = sb_q.pop_front();
         assert ((obs & e.msk) === (e.exp & e.msk)) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b mask=%b", e.tag, obs, e.exp, e.msk);
         end
      end
   endtask

   function automatic stim_t lu(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd);
      stim_t v = '0;
      v.rs1_re  = 1'b1;
      v.rs2_re  = 1'b1;
      v.rs1     = rs1;
      v.rs2     = rs2;
      v.rd_we   = 1'b1;
      v.rd      = rd;
      v.is_load = 1'b1;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      s = '0;
      apply(s);
      // Reset with live hazard/memory inputs: everything must stay low.
      s = lu(5'd5, 5'd0, 5'd5); s.req = 1'b1; s.rst = 1'b1;
      step(O_NONE, M_ALL, "reset0");
      step(O_NONE, M_ALL, "reset1");
      s = '0;
      step(O_NONE, M_ALL, "idle");

      // Load-use variants
      s = lu(5'd5, 5'd0, 5'd5);   step(O_LU, M_ALL, "lu_rs1");
      s = '0;                     step(O_NONE, M_ALL, "lu_after");
      s = lu(5'd1, 5'd7, 5'd7);   step(O_LU, M_ALL, "lu_rs2");
      s = lu(5'd0, 5'd0, 5'd0);   step(O_NONE, M_ALL, "lu_x0");
      s = lu(5'd9, 5'd3, 5'd9); s.rs1_re = 1'b0;  step(O_NONE, M_ALL, "lu_no_re");
      s = lu(5'd9, 5'd3, 5'd9); s.rd_we = 1'b0;   step(O_NONE, M_ALL, "lu_no_we");
      s = lu(5'd9, 5'd3, 5'd9); s.is_load = 1'b0; step(O_NONE, M_ALL, "lu_no_load");

      // Branch beats load-use
      s = lu(5'd5, 5'd0, 5'd5); s.br = 1'b1; step(O_BR, M_ALL, "br_over_lu");
      s = '0; s.br = 1'b1;                   step(O_BR, M_ALL, "br_alone");

      // MDU: 3 busy cycles, release on the 4th, then back in RUN
      s = '0; s.mdu = 1'b1;  step(O_MDU, M_ALL, "mdu_c1");
      s = lu(5'd4, 5'd0, 5'd4); s.br = 1'b1; step(O_MDU, M_ALL, "mdu_c2_masks");
      s = '0;                step(O_MDU, M_ALL, "mdu_c3");
      s = '0;                step(O_NONE, M_ALL, "mdu_release");
      s = '0; s.br = 1'b1;   step(O_BR, M_ALL, "mdu_back_run");

      // MEM freeze of 5 cycles in the middle of an MDU operation
      s = '0; s.mdu = 1'b1;  step(O_MDU, M_ALL, "mdumem_c1");
      s = '0;                step(O_MDU, M_ALL, "mdumem_c2");
      s = '0; s.req = 1'b1;
      for (int i = 0; i < 5; i++) step(O_FRZ, M_FRZ, $sformatf("mdumem_frz%0d", i));
      s.ack = 1'b1;          step(O_MDU, M_ALL, "mdumem_ack_c3");
      s = '0;                step(O_NONE, M_ALL, "mdumem_release");
      s = '0; s.br = 1'b1;   step(O_BR, M_ALL, "mdumem_back_run");

      // Ack without a request is ignored
      s = lu(5'd6, 5'd0, 5'd6); s.ack = 1'b1; step(O_LU, M_ALL, "ack_no_req");

      // Timeout: 7 frozen cycles, error pulse on the 8th, then advance
      s = '0; s.req = 1'b1;
      for (int i = 0; i < 7; i++) step(O_FRZ, M_FRZ, $sformatf("to_frz%0d", i));
      step(O_TO, M_ALL, "to_pulse");
      s = '0;                step(O_NONE, M_ALL, "to_after");

      // A redirect during a freeze waits for the ack cycle
      s = '0; s.req = 1'b1; s.br = 1'b1; step(O_FRZ, M_FRZ, "br_defer_frz");
      s.ack = 1'b1;                      step(O_BR, M_ALL, "br_defer_ack");

      // Reset mid-MEM clears the wait counter: a full 8 cycles to timeout afterwards
      s = '0; s.req = 1'b1;
      for (int i = 0; i < 5; i++) step(O_FRZ, M_FRZ, $sformatf("rstmem_frz%0d", i));
      s.rst = 1'b1;          step(O_NONE, M_ALL, "rstmem_rst");
      s = '0;                step(O_NONE, M_ALL, "rstmem_idle");
      s = '0; s.req = 1'b1;
      for (int i = 0; i < 7; i++) step(O_FRZ, M_FRZ, $sformatf("rstmem_refrz%0d", i));
      step(O_TO, M_ALL, "rstmem_to");

      // Reset mid-MDU aborts occupancy
      s = '0; s.mdu = 1'b1;  step(O_MDU, M_ALL, "rstmdu_c1");
      s = '0; s.rst = 1'b1;  step(O_NONE, M_ALL, "rstmdu_rst");
      s = '0; s.br = 1'b1;   step(O_BR, M_ALL, "rstmdu_run");
      s = '0;                step(O_NONE, M_ALL, "final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
